// File: rtl/binary_gray.sv
// binary_gray
//   Registered 4-bit code converter. Each cycle with in_valid high, the
//   source word {B_3,B_2,B_1,B_0} is converted and loaded into
//   {G_3,G_2,G_1,G_0} on the next rising clk edge. out_valid is high for
//   exactly that one cycle. When in_valid is low, G holds its previous
//   value and out_valid drops.
//   mode = 0 : binary -> Gray  (each bit XORs with its upper neighbour)
//   mode = 1 : Gray -> binary  (each bit is the XOR of itself and all
//                               higher source bits)
//
// Ports
//   G_3..G_0   out  converted word, registered (G_3 = MSB)
//   B_0..B_3   in   source word (B_3 = MSB)
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset; clears G and out_valid
//   mode       in   conversion direction, sampled per word
//   in_valid   in   qualifies B and mode in the current cycle
//   out_valid  out  one-cycle strobe marking a newly converted G
//
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.

module binary_gray (
    output logic G_3,
    output logic G_2,
    output logic G_1,
    output logic G_0,
    input  logic B_0,
    input  logic B_1,
    input  logic B_2,
    input  logic B_3,
    input  logic clk,
    input  logic rst_n,
    input  logic mode,
    input  logic in_valid,
    output logic out_valid
);

    logic [3:0] src_word;
    logic [3:0] to_gray;
    logic [3:0] to_bin;
    logic [3:0] conv_word;
    logic [3:0] g_reg;
    logic       valid_reg;

    assign src_word = {B_3, B_2, B_1, B_0};

    // Binary to Gray: each bit is XORed with the next-higher source bit.
    assign to_gray[3] = src_word[3];
    assign to_gray[2] = src_word[3] ^ src_word[2];
    assign to_gray[1] = src_word[2] ^ src_word[1];
    assign to_gray[0] = src_word[1] ^ src_word[0];

    // Gray to binary: each bit is the running XOR from the MSB down.
    // This is written as a ripple chain so each stage reuses the one above.
    assign to_bin[3] = src_word[3];
    assign to_bin[2] = to_bin[3] ^ src_word[2];
    assign to_bin[1] = to_bin[2] ^ src_word[1];
    assign to_bin[0] = to_bin[1] ^ src_word[0];

    assign conv_word = mode ? to_bin : to_gray;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_reg     <= 4'b0000;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                g_reg <= conv_word;
            end
        end
    end

    assign G_3       = g_reg[3];
    assign G_2       = g_reg[2];
    assign G_1       = g_reg[1];
    assign G_0       = g_reg[0];
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_binary_gray.sv
// tb_binary_gray
//   Self-checking bench for binary_gray. Expected values come from a
//   behavioural model: Gray code as n ^ (n >> 1), and the inverse found by
//   searching for the binary word whose Gray code matches.

module tb_binary_gray;

    logic clk;
    logic rst_n;
    logic mode;
    logic in_valid;
    logic out_valid;
    logic B_0, B_1, B_2, B_3;
    logic G_0, G_1, G_2, G_3;

    int n_cmp;
    int n_err;

    logic [3:0] exp_g;
    logic       exp_v;

    binary_gray dut (
        .G_3      (G_3),
        .G_2      (G_2),
        .G_1      (G_1),
        .G_0      (G_0),
        .B_0      (B_0),
        .B_1      (B_1),
        .B_2      (B_2),
        .B_3      (B_3),
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .out_valid(out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] gray_of(input logic [3:0] n);
        return n ^ (n >> 1);
    endfunction

    function automatic logic [3:0] bin_of(input logic [3:0] g);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (gray_of(4'(k)) == g) r = 4'(k);
        end
        return r;
    endfunction

    function automatic logic [3:0] model_conv(input logic [3:0] b, input logic m);
        return m ? bin_of(b) : gray_of(b);
    endfunction

    function automatic logic [3:0] g_now();
        return {G_3, G_2, G_1, G_0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Drive one cycle of input at the falling edge, update the model at the
    // rising edge, then compare G and out_valid just after it.
    task automatic step(input string tag, input logic [3:0] b, input logic m, input logic v);
        @(negedge clk);
        {B_3, B_2, B_1, B_0} = b;
        mode     = m;
        in_valid = v;
        @(posedge clk);
        if (rst_n) begin
            exp_v = v;
            if (v) exp_g = model_conv(b, m);
        end else begin
            exp_g = 4'd0;
            exp_v = 1'b0;
        end
        #1;
        chk({tag, "_g"}, 32'(g_now()), 32'(exp_g));
        chk({tag, "_v"}, 32'(out_valid), 32'(exp_v));
    endtask

    initial begin
        logic [3:0] prev_g;
        logic [3:0] fwd;
        logic [3:0] rb;
        n_cmp = 0;
        n_err = 0;
        exp_g = 4'd0;
        exp_v = 1'b0;
        rst_n = 1'b1;
        mode = 1'b0;
        in_valid = 1'b0;
        {B_3, B_2, B_1, B_0} = 4'd0;

        // Reset asserted before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_g", 32'(g_now()), 32'd0);
        chk("rst_async_v", 32'(out_valid), 32'd0);

        // Clock edges with in_valid high are ignored while in reset.
        step("rst_hold", 4'b1010, 1'b0, 1'b1);
        step("rst_hold", 4'b0111, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step("idle", 4'b0000, 1'b0, 1'b0);

        // Single conversion then hold.
        step("single", 4'b1010, 1'b0, 1'b1);
        chk("single_1111", 32'(g_now()), 32'hF);
        step("hold", 4'b0101, 1'b0, 1'b0);
        chk("hold_1111", 32'(g_now()), 32'hF);

        // Exhaustive forward sweep, back to back, with one-bit adjacency.
        prev_g = 4'd0;
        for (int n = 0; n < 16; n++) begin
            step("sweep", 4'(n), 1'b0, 1'b1);
            if (n > 0) chk("adj", 32'($countones(g_now() ^ prev_g)), 32'd1);
            prev_g = g_now();
        end
        step("wrap", 4'd0, 1'b0, 1'b1);
        chk("wrap_adj", 32'($countones(g_now() ^ prev_g)), 32'd1);

        // Inverse directed points.
        step("inv_f", 4'b1111, 1'b1, 1'b1);
        chk("inv_1010", 32'(g_now()), 32'hA);
        step("inv_8", 4'b1000, 1'b1, 1'b1);
        chk("inv_1111", 32'(g_now()), 32'hF);

        // Round trips: forward conversion fed back through the inverse.
        for (int n = 0; n < 16; n++) begin
            step("rt_fwd", 4'(n), 1'b0, 1'b1);
            fwd = g_now();
            step("rt_inv", fwd, 1'b1, 1'b1);
            rb = g_now();
            chk("roundtrip", 32'(rb), 32'(n));
        end

        // Mid-stream reset pulse between edges.
        step("ms_a", 4'b0101, 1'b0, 1'b1);
        step("ms_b", 4'b1101, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_g = 4'd0;
        exp_v = 1'b0;
        chk("ms_rst_g", 32'(g_now()), 32'd0);
        chk("ms_rst_v", 32'(out_valid), 32'd0);
        #1 rst_n = 1'b1;
        step("ms_after", 4'b0011, 1'b0, 1'b1);
        chk("ms_0010", 32'(g_now()), 32'h2);

        // Mode switch between consecutive valid words.
        step("msw0", 4'b0110, 1'b0, 1'b1);
        chk("msw_0101", 32'(g_now()), 32'h5);
        step("msw1", 4'b0110, 1'b1, 1'b1);
        chk("msw_0100", 32'(g_now()), 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
